// File: rtl/window_serializer_if.sv
// Handshake bundle for window_serializer.
//   in_data/in_valid/in_ready   : window capture channel (upstream -> block)
//   out_data/out_idx/out_last/
//   out_valid/out_ready         : element stream channel (block -> downstream)
//   busy                        : block is streaming a window
// The slave modport is the block's view; master is the environment's view.
interface window_serializer_if #(
    parameter int BIT_DEPTH = 8,
    parameter int NUM_IN    = 9,
    parameter int IDX_W     = $clog2(NUM_IN)
) ();
    logic [NUM_IN*BIT_DEPTH-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [BIT_DEPTH-1:0]        out_data;
    logic [IDX_W-1:0]            out_idx;
    logic                        out_last;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_last, out_valid, busy
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_last, out_valid, busy
    );
endinterface

// File: rtl/window_serializer.sv
// window_serializer: captures a whole window of NUM_IN elements in a single
// valid/ready handshake, then streams the elements out one per accepted beat
// with an internally sequenced index.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : window_serializer_if slave modport (capture + stream channels)
module window_serializer #(
    parameter int BIT_DEPTH = 8,
    parameter int NUM_IN    = 9,
    parameter int IDX_W     = $clog2(NUM_IN)
) (
    input  logic                clk,
    input  logic                rst_n,
    window_serializer_if.slave  bus
);

    localparam logic [0:0]       IDLE     = 1'b0;
    localparam logic [0:0]       STREAM   = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    logic [0:0]                  state_reg;
    logic [0:0]                  state_next;
    logic [IDX_W-1:0]            cnt_reg;
    logic [IDX_W-1:0]            cnt_next;
    logic [NUM_IN*BIT_DEPTH-1:0] win_flat;
    logic [BIT_DEPTH-1:0]        sel_data;
    logic                        out_valid;
    logic                        out_last;
    logic                        beat_accept;
    logic                        capture;

    assign out_valid   = (state_reg == STREAM);
    assign out_last    = out_valid && (cnt_reg == LAST_IDX);
    assign beat_accept = out_valid & bus.out_ready;
    // A new window may be taken while idle, or on the edge that retires the
    // last element so consecutive windows stream without a bubble.
    assign bus.in_ready = (state_reg == IDLE) | (beat_accept & out_last);
    assign capture      = bus.in_valid & bus.in_ready;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (capture) begin
            state_next = STREAM;
            cnt_next   = '0;
        end else if (beat_accept) begin
            // Wrap explicitly at NUM_IN-1 so non-power-of-two windows never
            // expose an out-of-range index.
            if (cnt_reg == LAST_IDX) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Window bank: one register per element, loaded only on capture, so the
    // contents are frozen for the whole stream.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_bank
            logic [BIT_DEPTH-1:0] elem_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    elem_reg <= '0;
                end else if (capture) begin
                    elem_reg <= bus.in_data[gi*BIT_DEPTH +: BIT_DEPTH];
                end
            end

            assign win_flat[gi*BIT_DEPTH +: BIT_DEPTH] = elem_reg;
        end
    endgenerate

    // Element select driven only by the internal counter.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cnt_reg == IDX_W'(i)) begin
                sel_data = win_flat[i*BIT_DEPTH +: BIT_DEPTH];
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_idx   = cnt_reg;
    assign bus.out_data  = out_valid ? sel_data : '0;
    assign bus.busy      = out_valid;

endmodule

// File: tb/tb_window_serializer.sv
// Self-checking bench for window_serializer: a table-driven first window,
// hand-written multi-cycle sequences, and random traffic against a queue-based
// reference model. A second instance covers NUM_IN=5, BIT_DEPTH=16.
module tb_window_serializer;

    logic clk;
    logic rst_n;

    window_serializer_if #(.BIT_DEPTH(8),  .NUM_IN(9)) if1 ();
    window_serializer_if #(.BIT_DEPTH(16), .NUM_IN(5)) if2 ();

    window_serializer #(.BIT_DEPTH(8), .NUM_IN(9)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    window_serializer #(.BIT_DEPTH(16), .NUM_IN(5)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] make_win(input logic [7:0] base, input logic [7:0] stp);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = base + stp * 8'(i);
        return w;
    endfunction

    // Reference model: the elements still owed downstream, in order.
    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } elem_t;
    elem_t q[$];

    bit         verbose = 1'b1;
    bit         acc_dut;
    logic [7:0] acc_data;
    logic [3:0] acc_idx;
    bit         ov_dut;
    bit         cap_model;

    // Called at a falling edge with inputs already driven; compares, then
    // advances the model across the rising edge and returns at the next fall.
    task automatic step(input string tag);
        elem_t       head;
        logic        e_ov, e_ir, e_last;
        logic [71:0] win;
        bit          acc_m, cap_m;
        elem_t       e;
        #1;
        e_ov = (q.size() != 0);
        head = '0;
        if (e_ov) head = q[0];
        e_last = e_ov && (head.idx == 4'd8);
        e_ir   = (q.size() == 0) || (q.size() == 1 && if1.out_ready);
        check({tag, ".in_ready"},  64'(if1.in_ready),  64'(e_ir));
        check({tag, ".out_valid"}, 64'(if1.out_valid), 64'(e_ov));
        check({tag, ".out_data"},  64'(if1.out_data),  64'(head.data));
        check({tag, ".out_idx"},   64'(if1.out_idx),   64'(head.idx));
        check({tag, ".out_last"},  64'(if1.out_last),  64'(e_last));
        check({tag, ".busy"},      64'(if1.busy),      64'(e_ov));
        ov_dut   = if1.out_valid;
        acc_dut  = if1.out_valid & if1.out_ready;
        acc_data = if1.out_data;
        acc_idx  = if1.out_idx;
        acc_m    = e_ov && if1.out_ready;
        cap_m    = if1.in_valid && e_ir;
        win      = if1.in_data;
        if (verbose && acc_dut) $display("[%s] beat idx=%0d data=%02h last=%0b", tag, acc_idx, acc_data, if1.out_last);
        if (verbose && cap_m)   $display("[%s] window captured", tag);
        @(posedge clk);
        if (acc_m) void'(q.pop_front());
        if (cap_m) begin
            for (int i = 0; i < 9; i++) begin
                e.idx  = 4'(i);
                e.data = win[i*8 +: 8];
                q.push_back(e);
            end
        end
        cap_model = cap_m;
        @(negedge clk);
    endtask

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       exp_ir;
        logic       exp_ov;
        logic [3:0] exp_idx;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;
    vec_t vecs [11];

    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic [71:0] w1, w2, w3;
    logic [7:0]  got_data [18];
    logic [3:0]  got_idx  [18];

    initial begin
        int n;
        int cyc;
        bit pulsed;
        logic [95:0] rnd;

        w1 = make_win(8'h11, 8'h11);
        w2 = make_win(8'hA0, 8'h01);
        w3 = make_win(8'h55, 8'h03);

        // Test 1 table: capture then nine beats at full throughput, then idle.
        vecs[0] = '{iv: 1'b1, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, exp_idx: 4'd0, exp_data: 8'h00, exp_last: 1'b0};
        for (int k = 1; k <= 9; k++)
            vecs[k] = '{iv: 1'b0, ordy: 1'b1, exp_ir: (k == 9), exp_ov: 1'b1, exp_idx: 4'(k-1),
                        exp_data: 8'(8'h11 * k), exp_last: (k == 9)};
        vecs[10] = '{iv: 1'b0, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, exp_idx: 4'd0, exp_data: 8'h00, exp_last: 1'b0};

        rst_n         = 1'b0;
        if1.in_data   = '0;
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b0;
        if2.in_data   = '0;
        if2.in_valid  = 1'b0;
        if2.out_ready = 1'b0;

        #2;
        check("rst.out_valid", 64'(if1.out_valid), 64'd0);
        check("rst.out_data",  64'(if1.out_data),  64'd0);
        check("rst.out_idx",   64'(if1.out_idx),   64'd0);
        check("rst.busy",      64'(if1.busy),      64'd0);
        check("rst.in_ready",  64'(if1.in_ready),  64'd1);
        check("rst.dut2_out_valid", 64'(if2.out_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: table-driven single window
        if1.in_data = w1;
        for (int k = 0; k < 11; k++) begin
            if1.in_valid  = vecs[k].iv;
            if1.out_ready = vecs[k].ordy;
            #1;
            check($sformatf("t1[%0d].in_ready", k),  64'(if1.in_ready),  64'(vecs[k].exp_ir));
            check($sformatf("t1[%0d].out_valid", k), 64'(if1.out_valid), 64'(vecs[k].exp_ov));
            check($sformatf("t1[%0d].out_idx", k),   64'(if1.out_idx),   64'(vecs[k].exp_idx));
            check($sformatf("t1[%0d].out_data", k),  64'(if1.out_data),  64'(vecs[k].exp_data));
            check($sformatf("t1[%0d].out_last", k),  64'(if1.out_last),  64'(vecs[k].exp_last));
            $display("[t1] vec %0d idx=%0d data=%02h valid=%0b", k, if1.out_idx, if1.out_data, if1.out_valid);
            @(posedge clk);
            @(negedge clk);
        end
        q.delete();

        // Test 2: backpressure pattern 1,0,0,1
        if1.in_data = w1; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        step("t2");
        if1.in_valid = 1'b0;
        n = 0; cyc = 0;
        for (int p = 0; p < 60 && n < 9; p++) begin
            if1.out_ready = pat[p % 4];
            step("t2");
            if (ov_dut) cyc++;
            if (acc_dut) begin
                got_data[n] = acc_data;
                n++;
            end
        end
        check("t2.accepts", 64'(n), 64'd9);
        check("t2.valid_cycles", 64'(cyc), 64'd17);
        for (int k = 0; k < 9 && k < n; k++)
            check($sformatf("t2.order[%0d]", k), 64'(got_data[k]), 64'(8'h11 * (k + 1)));

        // Test 3: back-to-back windows with no bubble
        if1.out_ready = 1'b1; if1.in_data = w1; if1.in_valid = 1'b1;
        step("t3");
        if1.in_data = w2;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step("t3");
            if (cap_model) if1.in_valid = 1'b0;
            if (ov_dut) begin
                if (n < 18) begin
                    got_idx[n]  = acc_idx;
                    got_data[n] = acc_data;
                end
                n++;
            end else if (n > 0) begin
                break;
            end
        end
        check("t3.run_length", 64'(n), 64'd18);
        for (int k = 0; k < 18 && k < n; k++) begin
            check($sformatf("t3.idx[%0d]", k), 64'(got_idx[k]), 64'(k % 9));
            check($sformatf("t3.data[%0d]", k), 64'(got_data[k]),
                  (k < 9) ? 64'(8'h11 * (k + 1)) : 64'(8'hA0 + (k - 9)));
        end

        // Test 4: window offered mid-stream must be ignored
        if1.in_data = w1; if1.in_valid = 1'b1;
        step("t4");
        n = 0; pulsed = 1'b0;
        for (int c = 0; c < 30 && n < 9; c++) begin
            if1.in_valid = 1'b0;
            if (!pulsed && q.size() != 0 && q[0].idx == 4'd3) begin
                if1.in_valid = 1'b1;
                if1.in_data  = w3;
                pulsed = 1'b1;
            end
            step("t4");
            if (acc_dut) begin
                got_data[n] = acc_data;
                n++;
            end
        end
        if1.in_valid = 1'b0;
        check("t4.pulsed", 64'(pulsed), 64'd1);
        check("t4.accepts", 64'(n), 64'd9);
        for (int k = 0; k < 9 && k < n; k++)
            check($sformatf("t4.data[%0d]", k), 64'(got_data[k]), 64'(8'h11 * (k + 1)));
        step("t4.idle");

        // Test 5: asynchronous reset in the middle of a stream
        if1.in_data = w1; if1.in_valid = 1'b1;
        step("t5");
        if1.in_valid = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0 && q[0].idx != 4'd5; c++) step("t5");
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.rst_out_valid", 64'(if1.out_valid), 64'd0);
        check("t5.rst_out_data",  64'(if1.out_data),  64'd0);
        check("t5.rst_out_idx",   64'(if1.out_idx),   64'd0);
        check("t5.rst_out_last",  64'(if1.out_last),  64'd0);
        check("t5.rst_busy",      64'(if1.busy),      64'd0);
        $display("[t5] reset asserted mid-stream");
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) step("t5.post");
        if1.in_data = w2; if1.in_valid = 1'b1;
        step("t5.recap");
        if1.in_valid = 1'b0;
        for (int c = 0; c < 10; c++) step("t5.recap");

        // Random traffic against the reference model
        verbose = 1'b0;
        for (int c = 0; c < 800; c++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            if1.in_data   = rnd[71:0];
            if1.in_valid  = ($urandom_range(0, 9) < 4);
            if1.out_ready = ($urandom_range(0, 9) < 7);
            step("rand");
        end
        $display("[rand] 800 random cycles applied");
        if1.in_valid = 1'b0;
        if1.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) step("drain");

        // Test 6: NUM_IN=5, BIT_DEPTH=16 instance, two windows back to back
        for (int i = 0; i < 5; i++) if2.in_data[i*16 +: 16] = 16'h1000 + 16'(i);
        if2.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic       e_ov, e_ir, e_last;
            logic [2:0] e_idx;
            logic [15:0] e_data;
            if2.in_valid = (c <= 5);
            #1;
            e_ov   = (c >= 1 && c <= 10);
            e_idx  = e_ov ? 3'((c - 1) % 5) : 3'd0;
            e_data = e_ov ? 16'h1000 + 16'(e_idx) : 16'h0000;
            e_last = e_ov && (e_idx == 3'd4);
            e_ir   = (c == 0) || (c == 5) || (c == 10) || (c == 11);
            check($sformatf("t6[%0d].out_valid", c), 64'(if2.out_valid), 64'(e_ov));
            check($sformatf("t6[%0d].out_idx", c),   64'(if2.out_idx),   64'(e_idx));
            check($sformatf("t6[%0d].out_data", c),  64'(if2.out_data),  64'(e_data));
            check($sformatf("t6[%0d].out_last", c),  64'(if2.out_last),  64'(e_last));
            check($sformatf("t6[%0d].in_ready", c),  64'(if2.in_ready),  64'(e_ir));
            check($sformatf("t6[%0d].idx_range", c), 64'(if2.out_idx <= 3'd4), 64'd1);
            $display("[t6] cycle %0d idx=%0d data=%04h valid=%0b last=%0b", c, if2.out_idx, if2.out_data, if2.out_valid, if2.out_last);
            @(posedge clk);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/window_serializer.md
Name: window_serializer

Overview:
Parametrised successor to the team's fixed 9:1 window mux. It captures a full window of NUM_IN elements in one handshake, then streams them out one element per accepted beat under valid/ready flow control, with an internally sequenced select. It sits between the window/line-buffer stage and a single-lane MAC in the NPU datapath.

Parameters:
BIT_DEPTH, 8, width of each element in bits
NUM_IN, 9, elements per window; legal range 2..64
IDX_W, $clog2(NUM_IN), width of the element index

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*BIT_DEPTH  flat window; element i is in_data[i*BIT_DEPTH +: BIT_DEPTH]
in_valid  input  1  window on in_data is valid
in_ready  output  1  block can accept a window this cycle
out_data  output  BIT_DEPTH  current element
out_idx  output  IDX_W  index of the current element, 0..NUM_IN-1
out_last  output  1  high when out_idx == NUM_IN-1 and out_valid is high
out_valid  output  1  out_data, out_idx and out_last are valid
out_ready  input  1  downstream accepts the current element
busy  output  1  high in the STREAM state

Behaviour:
- States: IDLE and STREAM. The reset state is IDLE.
- Asynchronous reset (rst_n low) has immediate effect:
  - state goes to IDLE and the index counter to 0;
  - out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, busy = 0;
  - the window register bank is cleared to 0.
- in_ready is combinational: in_ready = (state == IDLE) | (out_valid & out_ready & out_last).
- Window capture happens on any cycle where in_valid & in_ready:
  - all NUM_IN elements are registered;
  - the counter is set to 0;
  - state goes to STREAM.
- Output timing: out_valid rises on the cycle after capture, with element 0. Latency from capture edge to first element is 1 cycle.
- In STREAM, out_valid = 1, and out_data = window[counter] is a registered-bank read through a mux. The select is the counter, never an external input.
- Beat accept is out_valid & out_ready:
  - if the counter < NUM_IN-1, the counter increments;
  - otherwise (last element) the counter goes to 0 and state goes to IDLE, unless a new window is captured on the same edge.
- Back-to-back windows: if the last beat is accepted and in_valid is high in the same cycle, the new window is captured and state stays STREAM. Element 0 of the new window appears on the next cycle, so there is no bubble.
- Backpressure: while out_ready = 0, out_data, out_idx and out_last hold stable and out_valid stays high. The window bank never changes during STREAM except at the last-beat capture.
- in_valid in STREAM before the last beat is ignored (in_ready = 0). The upstream must hold its data per valid/ready rules.
- Counter never exceeds NUM_IN-1, and out_idx is never out of range. For non-power-of-two NUM_IN, wrap is at NUM_IN-1, not 2^IDX_W-1.
- Reset asserted mid-stream aborts the window: the remaining elements are discarded and nothing is emitted after reset release until a new capture.
- out_data is 0 whenever out_valid = 0.
- Arithmetic: no data transformation; out_data is bit-exact with the selected element.

Test Plan:
1. Reset, then one window {0x11,0x22,...,0x99} with out_ready held 1 -> in_ready = 1 before capture. out_valid rises 1 cycle after capture. 9 consecutive beats with out_idx 0..8 and data 0x11..0x99. out_last only on idx 8. in_ready = 1 on that last-beat cycle, then IDLE.
2. Same window, out_ready toggling 1,0,0,1 repeating -> each element is held stable while stalled. The 9 elements arrive in order, with no duplicates and no drops. Total cycles = 9 accepts plus the stall count.
3. Back-to-back: second window {0xA0..0xA8} presented with in_valid high throughout -> captured on the last beat of the first window. 18 contiguous out_valid cycles with no gap, and out_idx sequence 0..8,0..8.
4. in_valid pulsed with a different window during STREAM (idx 3) -> in_ready = 0 and the window is ignored. The stream continues with original data 0x44..0x99.
5. rst_n driven low asynchronously (mid-cycle) at idx 5 -> outputs go to 0 immediately. After release: in_ready = 1, busy = 0, out_valid stays 0 until a new capture.
6. NUM_IN=5, BIT_DEPTH=16 build, window {0x1000..0x1004} -> out_idx 0..4, wrapping to 0 (never 5..7). out_last on idx 4, and data is bit-exact.
